// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg: shared widths and helpers for the
// 256-bit packet sink and its 64-bit lane reader.
package stream_fifo_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 64;
  localparam int WORD_W = 256;

  typedef logic [1:0] lane_t;

  // One extra bit tells a full buffer from an empty one.
  function automatic int ptr_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_sink_if.sv
// stream_fifo_sink_if: producer conduit plus the 64-bit
// consumer port and the packet counters.
interface stream_fifo_sink_if;
  import stream_fifo_pkg::*;

  logic [WORD_W-1:0] fifo_stream_fifo_data;
  logic              fifo_stream_fifo_write;
  logic              fifo_stream_fifo_send;
  logic [LANE_W-1:0] from_fifo_fifo_data;
  logic              from_fifo_fifo_read;
  logic              from_fifo_fifo_empty;
  logic              from_fifo_fifo_full;
  logic [15:0]       drop_count;
  logic [15:0]       pkt_count;

  modport master (
    output fifo_stream_fifo_data,
    output fifo_stream_fifo_write,
    output fifo_stream_fifo_send,
    input  from_fifo_fifo_data,
    output from_fifo_fifo_read,
    input  from_fifo_fifo_empty,
    input  from_fifo_fifo_full,
    input  drop_count,
    input  pkt_count
  );

  modport slave (
    input  fifo_stream_fifo_data,
    input  fifo_stream_fifo_write,
    input  fifo_stream_fifo_send,
    output from_fifo_fifo_data,
    input  from_fifo_fifo_read,
    output from_fifo_fifo_empty,
    output from_fifo_fifo_full,
    output drop_count,
    output pkt_count
  );

endinterface

// File: rtl/stream_fifo_sink_sdp_ram_256.sv
// sdp_ram_256: one write port, one registered read port.
// The read register doubles as the output stage.
module sdp_ram_256
  import stream_fifo_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [2**AW];

  // Storage array write.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  // Registered read; cleared so the lane output is 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/stream_fifo_sink.sv
// stream_fifo_sink: packet-commit buffer for 256-bit words,
// drained as 64-bit show-ahead lanes.
module stream_fifo_sink
  import stream_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2   = 6,
  parameter int AFULL_MARGIN = 4
) (
  input logic         clk_clk,
  input logic         reset_reset,
  stream_fifo_sink_if.slave bus
);

  localparam int PW    = ptr_w(DEPTH_LOG2);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t AFULL_P = ptr_t'(DEPTH - AFULL_MARGIN);

  ptr_t  wr_ptr;
  ptr_t  commit_ptr;
  ptr_t  rd_ptr;
  ptr_t  used;
  ptr_t  wr_ptr_inc;
  ptr_t  rd_next;
  lane_t lane;

  logic pkt_bad;
  logic pkt_nonempty;
  logic out_valid;

  logic wr_ok;
  logic wr_drop;
  logic send_bad;
  logic send_commit;

  logic pop;
  logic pop_word;
  logic need;
  logic load;

  logic [15:0] drop_cnt;
  logic [15:0] pkt_cnt;

  logic [WORD_W-1:0]             rd_word;
  logic [LANES-1:0][LANE_W-1:0]  rd_lanes;

  // ---- write side ----
  assign used       = wr_ptr - rd_ptr;
  assign wr_ok      = bus.fifo_stream_fifo_write
                    && (used < DEPTH_P);
  assign wr_drop    = bus.fifo_stream_fifo_write
                    && !wr_ok;
  assign wr_ptr_inc = wr_ptr + ptr_t'(wr_ok);

  // A word lost in the send cycle spoils the packet too.
  assign send_bad    = bus.fifo_stream_fifo_send
                     && (pkt_bad || wr_drop);
  assign send_commit = bus.fifo_stream_fifo_send
                     && !send_bad
                     && (pkt_nonempty || wr_ok);

  // Speculative pointer, commit point and packet flags.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      pkt_bad      <= 1'b0;
      pkt_nonempty <= 1'b0;
      drop_cnt     <= '0;
      pkt_cnt      <= '0;
    end else begin
      if (send_bad)
        wr_ptr <= commit_ptr;
      else
        wr_ptr <= wr_ptr_inc;

      if (send_commit) begin
        commit_ptr <= wr_ptr_inc;
        pkt_cnt    <= pkt_cnt + 16'd1;
      end

      if (send_bad && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;

      if (bus.fifo_stream_fifo_send) begin
        pkt_bad      <= 1'b0;
        pkt_nonempty <= 1'b0;
      end else begin
        if (wr_ok)
          pkt_nonempty <= 1'b1;
        if (wr_drop)
          pkt_bad <= 1'b1;
      end
    end
  end

  // ---- read side ----
  // out_valid: the word at rd_ptr sits in the RAM read
  // register. The next word is fetched on the same edge
  // that retires lane 3, so word boundaries add no bubble.
  assign pop      = bus.from_fifo_fifo_read && out_valid;
  assign pop_word = pop && (lane == 2'd3);
  assign rd_next  = rd_ptr + ptr_t'(pop_word);
  assign need     = !out_valid || pop_word;
  assign load     = need && (rd_next != commit_ptr);

  // Read pointer, lane counter and output-stage valid.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rd_ptr    <= '0;
      lane      <= '0;
      out_valid <= 1'b0;
    end else begin
      rd_ptr <= rd_next;
      if (pop)
        lane <= lane + 2'd1;
      if (need)
        out_valid <= load;
    end
  end

  sdp_ram_256 #(
    .AW (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
    .wr_data (bus.fifo_stream_fifo_data),
    .rd_en   (load),
    .rd_addr (rd_next[DEPTH_LOG2-1:0]),
    .rd_data (rd_word)
  );

  assign rd_lanes = rd_word;

  assign bus.from_fifo_fifo_data  = rd_lanes[lane];
  assign bus.from_fifo_fifo_empty = !out_valid;
  assign bus.from_fifo_fifo_full  = (used >= AFULL_P);
  assign bus.drop_count           = drop_cnt;
  assign bus.pkt_count            = pkt_cnt;

endmodule

// File: tb/tb_stream_fifo_sink.sv
// tb_stream_fifo_sink: directed checks of commit, drop,
// lane order and reset, plus a random scoreboard run.
module tb_stream_fifo_sink;

  logic clk;
  logic rst;

  stream_fifo_sink_if bus ();

  stream_fifo_sink #(
    .DEPTH_LOG2   (3),
    .AFULL_MARGIN (4)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lv(input int n);
    return 64'hA5A5_0000_0000_0000 | 64'(n);
  endfunction

  function automatic logic [255:0] mk_word(input int b);
    logic [255:0] w;
    for (int i = 0; i < 4; i++)
      w[64*i +: 64] = lv(b + i);
    return w;
  endfunction

  task automatic push(input int b, input logic snd);
    bus.fifo_stream_fifo_data  = mk_word(b);
    bus.fifo_stream_fifo_write = 1'b1;
    bus.fifo_stream_fifo_send  = snd;
    @(negedge clk);
    bus.fifo_stream_fifo_write = 1'b0;
    bus.fifo_stream_fifo_send  = 1'b0;
  endtask

  task automatic read_seq(input string tag,
                          input int b, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_nonempty"},
          64'(bus.from_fifo_fifo_empty), 64'd0);
      chk(tag, bus.from_fifo_fifo_data, lv(b + i));
      bus.from_fifo_fifo_read = 1'b1;
      @(negedge clk);
    end
    bus.from_fifo_fifo_read = 1'b0;
    chk({tag, "_empty_end"},
        64'(bus.from_fifo_fifo_empty), 64'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"},
        64'(bus.from_fifo_fifo_empty), 64'd1);
    chk({tag, "_full"},
        64'(bus.from_fifo_fifo_full), 64'd0);
    chk({tag, "_data"}, bus.from_fifo_fifo_data, 64'd0);
    chk({tag, "_drop"}, 64'(bus.drop_count), 64'd0);
    chk({tag, "_pkt"}, 64'(bus.pkt_count), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  logic [63:0]  pend [$];
  logic [63:0]  expq [$];
  logic [63:0]  lane_v;
  logic [255:0] wrd;
  int  started, sent, remaining, tb_words;
  int  lanes_rd, cyc, len, exp_pkts;
  bit  send_next;

  initial begin
    rst = 1'b1;
    bus.fifo_stream_fifo_data  = '0;
    bus.fifo_stream_fifo_write = 1'b0;
    bus.fifo_stream_fifo_send  = 1'b0;
    bus.from_fifo_fifo_read    = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst0");
    rst = 1'b0;
    @(negedge clk);

    // single packet, separate send
    push(0, 1'b0);
    push(4, 1'b0);
    bus.fifo_stream_fifo_send = 1'b1;
    @(negedge clk);
    bus.fifo_stream_fifo_send = 1'b0;
    chk("t1_lat1_empty",
        64'(bus.from_fifo_fifo_empty), 64'd1);
    @(negedge clk);
    read_seq("t1_lane", 0, 8);
    chk("t1_pkt", 64'(bus.pkt_count), 64'd1);

    // final write with send in the same cycle
    push(8, 1'b0);
    push(12, 1'b1);
    chk("t2_lat1_empty",
        64'(bus.from_fifo_fifo_empty), 64'd1);
    @(negedge clk);
    read_seq("t2_lane", 8, 8);
    chk("t2_pkt", 64'(bus.pkt_count), 64'd2);

    // send without writes
    bus.fifo_stream_fifo_send = 1'b1;
    @(negedge clk);
    bus.fifo_stream_fifo_send = 1'b0;
    @(negedge clk);
    chk("t3_empty", 64'(bus.from_fifo_fifo_empty), 64'd1);
    chk("t3_pkt", 64'(bus.pkt_count), 64'd2);
    chk("t3_wr_ptr", 64'(dut.wr_ptr), 64'd4);
    chk("t3_commit", 64'(dut.commit_ptr), 64'd4);

    // overflow drop
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("rst1");
    push(16, 1'b0);
    push(20, 1'b1);
    chk("t4_full_u2", 64'(bus.from_fifo_fifo_full), 64'd0);
    for (int k = 1; k <= 8; k++) begin
      bus.fifo_stream_fifo_data  = mk_word(100 + 4*k);
      bus.fifo_stream_fifo_write = 1'b1;
      @(negedge clk);
      chk($sformatf("t4_full_k%0d", k),
          64'(bus.from_fifo_fifo_full),
          64'((2 + ((k < 6) ? k : 6)) >= 4));
    end
    bus.fifo_stream_fifo_write = 1'b0;
    bus.fifo_stream_fifo_send  = 1'b1;
    @(negedge clk);
    bus.fifo_stream_fifo_send  = 1'b0;
    chk("t4_drop", 64'(bus.drop_count), 64'd1);
    chk("t4_pkt", 64'(bus.pkt_count), 64'd1);
    chk("t4_wr_ptr", 64'(dut.wr_ptr), 64'd2);
    chk("t4_full_after", 64'(bus.from_fifo_fifo_full), 64'd0);
    read_seq("t4_lane", 16, 8);
    exp_pkts = 1;

    // random concurrent packets against a scoreboard
    started   = 0;
    sent      = 0;
    remaining = 0;
    tb_words  = 0;
    lanes_rd  = 0;
    cyc       = 0;
    send_next = 1'b0;
    while (sent < 1000 && cyc < 60000) begin
      cyc++;
      bus.fifo_stream_fifo_write = 1'b0;
      bus.fifo_stream_fifo_send  = 1'b0;
      if (send_next) begin
        bus.fifo_stream_fifo_send = 1'b1;
        send_next = 1'b0;
        expq = {expq, pend};
        pend.delete();
        sent++;
      end else begin
        if (remaining == 0 && started < 1000) begin
          len = $urandom_range(1, 4);
          if (tb_words + len <= 8) begin
            remaining = len;
            started++;
          end
        end
        if (remaining > 0 && $urandom_range(0, 3) != 0) begin
          for (int i = 0; i < 4; i++) begin
            lane_v = {$urandom, $urandom};
            wrd[64*i +: 64] = lane_v;
            pend.push_back(lane_v);
          end
          bus.fifo_stream_fifo_data  = wrd;
          bus.fifo_stream_fifo_write = 1'b1;
          tb_words++;
          remaining--;
          if (remaining == 0) begin
            if ($urandom_range(0, 1) == 1) begin
              bus.fifo_stream_fifo_send = 1'b1;
              expq = {expq, pend};
              pend.delete();
              sent++;
            end else begin
              send_next = 1'b1;
            end
          end
        end
      end
      bus.from_fifo_fifo_read = 1'b0;
      if (!bus.from_fifo_fifo_empty &&
          $urandom_range(0, 3) != 0) begin
        bus.from_fifo_fifo_read = 1'b1;
        if (expq.size() == 0)
          chk("rand_spurious",
              64'(bus.from_fifo_fifo_empty), 64'd1);
        else
          chk("rand_lane", bus.from_fifo_fifo_data,
              expq.pop_front());
        lanes_rd++;
        if (lanes_rd % 4 == 0)
          tb_words--;
      end
      @(negedge clk);
    end
    bus.fifo_stream_fifo_write = 1'b0;
    bus.fifo_stream_fifo_send  = 1'b0;
    chk("rand_budget", 64'(sent), 64'd1000);
    exp_pkts += sent;

    cyc = 0;
    while (expq.size() != 0 && cyc < 4000) begin
      cyc++;
      bus.from_fifo_fifo_read = 1'b0;
      if (!bus.from_fifo_fifo_empty) begin
        bus.from_fifo_fifo_read = 1'b1;
        chk("drain_lane", bus.from_fifo_fifo_data,
            expq.pop_front());
      end
      @(negedge clk);
    end
    bus.from_fifo_fifo_read = 1'b0;
    @(negedge clk);
    chk("drain_left", 64'(expq.size()), 64'd0);
    chk("drain_empty",
        64'(bus.from_fifo_fifo_empty), 64'd1);
    chk("rand_drop", 64'(bus.drop_count), 64'd1);
    chk("rand_pkt", 64'(bus.pkt_count),
        64'(exp_pkts & 16'hFFFF));

    // reset mid-packet and mid-read
    push(200, 1'b0);
    push(204, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("t6_pre", bus.from_fifo_fifo_data, lv(200 + i));
      bus.from_fifo_fifo_read = 1'b1;
      @(negedge clk);
    end
    bus.from_fifo_fifo_read = 1'b0;
    push(208, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("rst2");
    @(negedge clk);
    rst = 1'b0;
    push(300, 1'b1);
    @(negedge clk);
    read_seq("t6_post", 300, 4);
    chk("t6_pkt", 64'(bus.pkt_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_fifo_sink.md
# stream_fifo_sink

Receiving end of the 256-bit `fifo_stream` conduit driven by the DMA FIFO subsystems (`fifo_data`/`fifo_write`/`fifo_send`). It buffers 256-bit words in packet-commit mode and serves them to a 64-bit `from_fifo`-style consumer (`fifo_data`/`fifo_read`/`fifo_empty`/`fifo_full`). The conduit has no backpressure, so the block flags almost-full and drops overflowed packets whole. It sits between a DMA streaming master and any 64-bit consumer, e.g. the `from_fifo` input of another system.

## Interface
Parameters:
- `DEPTH_LOG2`, default 6: buffer depth is 2^DEPTH_LOG2 words of 256 bits.
- `AFULL_MARGIN`, default 4: `fifo_full` asserts when free words ≤ AFULL_MARGIN.

Ports:
- `clk_clk` in 1: single clock. All logic is on its rising edge.
- `reset_reset` in 1: reset, asynchronous and active-high.
- `fifo_stream_fifo_data` in 256: write word.
- `fifo_stream_fifo_write` in 1: push `fifo_data` this cycle.
- `fifo_stream_fifo_send` in 1: commit the current packet (end of packet).
- `from_fifo_fifo_data` out 64: current 64-bit lane (show-ahead).
- `from_fifo_fifo_read` in 1: consume the current lane.
- `from_fifo_fifo_empty` out 1: no committed lane available.
- `from_fifo_fifo_full` out 1: almost-full warning to the producer.
- `drop_count` out 16: number of dropped packets; saturates at 0xFFFF.
- `pkt_count` out 16: number of committed packets; wraps modulo 2^16.

## Operation
- Pointers are DEPTH_LOG2+1 bits: `wr_ptr` (speculative), `commit_ptr`, `rd_ptr`.
- `used = wr_ptr - rd_ptr`, computed modulo 2^(DEPTH_LOG2+1).
- Write with `used < DEPTH`:
  - store the word at `wr_ptr`;
  - increment `wr_ptr`;
  - set `pkt_nonempty`.
- Write with `used == DEPTH`: the word is discarded and `pkt_bad` is set.
- Send with `pkt_bad == 0` and (`pkt_nonempty` or write in the same cycle):
  - `commit_ptr <= wr_ptr` (including any same-cycle word);
  - `pkt_count++`.
- Send with `pkt_bad == 1`:
  - `wr_ptr <= commit_ptr`, which discards the entire packet;
  - `drop_count` increments, saturating.
- Send with an empty packet and no same-cycle write: no effect.
- Every send clears `pkt_bad` and `pkt_nonempty`.
- Read side:
  - 2-bit lane counter; lane 0 = bits [63:0] is output first, lane 3 = bits [255:192] last.
  - `read` while `empty == 0`: advance the lane; on lane 3, wrap to 0 and increment `rd_ptr`.
  - `read` while `empty == 1`: ignored, with no state change.
- `empty` is 1 when no committed word is loaded in the output stage.
- `full = (used >= 2^DEPTH_LOG2 - AFULL_MARGIN)`.

## Timing
- Reset values:
  - all pointers, lane counter, `pkt_bad`, `pkt_nonempty` = 0;
  - `empty = 1`, `full = 0`, `fifo_data = 0`, `drop_count = 0`, `pkt_count = 0`.
- Reset mid-operation: committed and uncommitted data are lost immediately.
- Write/send are sampled at edge N. `full` reflects the new `used` from cycle N+1.
- Commit latency into an empty buffer: a send sampled at edge N gives `empty = 0` and valid `fifo_data` in cycle N+2 (exactly 2 clocks).
- A `read` sampled at edge M presents the next lane in cycle M+1.
- Sustained reads run at 1 lane per clock with no bubble at word boundaries while committed words remain.
- `empty` rises in the cycle after the last committed lane is read.
- Same-cycle read-side pop and write-side push or commit are both honoured. `used` is computed from the post-edge pointers.
- Uncommitted words never become visible. A rollback never moves below `rd_ptr`: `commit_ptr ≥ rd_ptr` holds as an invariant.

## Structure
- Package `stream_fifo_pkg` holds:
  - `LANES = 4`, `LANE_W = 64`, `WORD_W = 256`;
  - lane index typedef;
  - a pointer-width function of DEPTH_LOG2.
- One sub-module, `sdp_ram_256`: simple dual-port RAM with 2^DEPTH_LOG2 × 256 bits, a registered read, and one write port. The show-ahead prefetch (output stage plus next-address logic) lives in the top level.

## Test plan
- Single packet: 2 writes (word0 = 0x…03_02_01_00 per lane, word1 = lanes 4..7), then send; read continuously.
  - Expect `empty = 0` exactly 2 cycles after send.
  - Expect the lane sequence 0,1,2,3,4,5,6,7 with no bubble.
  - Expect `empty = 1` after lane 7 and `pkt_count = 1`.
- Write with send in the same cycle on the final word: that word is included, the packet commits, and `pkt_count` increments.
- Send with no writes: pointers unchanged, `pkt_count` unchanged, `empty` stays 1.
- Overflow (DEPTH_LOG2 = 3), with a prior committed packet of 2 words and no reads:
  - Write 8 words, then send.
  - `full` rises once `used ≥ 4`.
  - The packet is dropped: `drop_count = 1`, `wr_ptr` returns to 2, and only the original 2 words (8 lanes) are read.
- Concurrency: interleave reads and commits continuously for 1000 random packets against a scoreboard. Expect no loss, no reordering, and lanes in order.
- Reset asserted mid-packet and mid-read: outputs return to reset values immediately. A new packet written after release reads back correctly.
